// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colour types and the RGB332 -> 4-4-4 expansion.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Replicate the top bits so full-scale 332 maps to full-scale 4-bit on every channel.
    function automatic rgb444_t expand332(input rgb332_t c);
        rgb444_t o;
        o.r = {c.r, c.r[2]};
        o.g = {c.g, c.g[2]};
        o.b = {c.b, c.b};
        return o;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_regs
        logic [WIDTH-1:0] stages [DEPTH];

        // NOTE: every stage is cleared on reset (not left as an unreset memory) so that
        // sync/blank flags leaving the line after reset are guaranteed inactive.
        always_ff @(posedge clk) begin
            if (!resetN) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
            end else begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_frame_driver.sv
// VGA raster generator: pixel counters, sync/blank decode realigned to the object-mux colour
// latency, and the registered 4-4-4 DAC outputs.
module vga_frame_driver
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [7:0]       RGBIn,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             startOfFrame,
    output logic             hSync,
    output logic             vSync,
    output logic             blankN,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [CNT_W-1:0] hCnt;
    logic [CNT_W-1:0] vCnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == CNT_W'(H_LEN - 1)) begin
            hCnt <= '0;
            vCnt <= (vCnt == CNT_W'(V_LEN - 1)) ? '0 : vCnt + CNT_W'(1);
        end else begin
            hCnt <= hCnt + CNT_W'(1);
        end
    end

    assign pixelX       = hCnt;
    assign pixelY       = vCnt;
    assign startOfFrame = (hCnt == '0) && (vCnt == '0);

    logic hs_raw;
    logic vs_raw;
    logic act_raw;

    assign hs_raw  = (hCnt >= CNT_W'(HS_FIRST)) && (hCnt <= CNT_W'(HS_LAST));
    assign vs_raw  = (vCnt >= CNT_W'(VS_FIRST)) && (vCnt <= CNT_W'(VS_LAST));
    assign act_raw = (hCnt < CNT_W'(H_ACTIVE)) && (vCnt < CNT_W'(V_ACTIVE));

    logic hs_d;
    logic vs_d;
    logic act_d;

    // Timing flags ride alongside the object-mux pipeline so they meet RGBIn on the same edge.
    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk    (clk),
        .resetN (resetN),
        .din    ({hs_raw, vs_raw, act_raw}),
        .dout   ({hs_d, vs_d, act_d})
    );

    rgb444_t colour;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            blankN <= 1'b0;
            colour <= '0;
        end else begin
            hSync  <= !hs_d;
            vSync  <= !vs_d;
            blankN <= act_d;
            colour <= act_d ? expand332(rgb332_t'(RGBIn)) : '0;
        end
    end

    assign red   = colour.r;
    assign green = colour.g;
    assign blue  = colour.b;

endmodule

// File: tb/tb_vga_frame_driver.sv
// Scoreboarded bench: a full-size 640x480 instance (PIPE_LAT=1) and a shrunken-raster
// instance (PIPE_LAT=3) so whole frames fit in a short run.
module tb_vga_frame_driver;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
    } geo_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } obs_t;

    localparam int RUN    = 2700;
    localparam int MID_N  = 1900;   // pixelX=300 on line 2 of the full-size raster
    localparam int HT2    = 25;
    localparam int VT2    = 11;

    geo_t geo1 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    geo_t geo2 = '{16, 2, 4, 3, 6, 1, 2, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst2;
    logic [7:0]  rgb1, rgb2;
    logic [10:0] x1, y1, x2, y2;
    logic        sof1, hs1, vs1, bn1, sof2, hs2, vs2, bn2;
    logic [3:0]  r1, gn1, b1, r2, gn2, b2;

    vga_frame_driver #(.PIPE_LAT(1)) dut1 (
        .clk(clk), .resetN(rst1), .RGBIn(rgb1),
        .pixelX(x1), .pixelY(y1), .startOfFrame(sof1),
        .hSync(hs1), .vSync(vs1), .blankN(bn1),
        .red(r1), .green(gn1), .blue(b1)
    );

    vga_frame_driver #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .PIPE_LAT(3)
    ) dut2 (
        .clk(clk), .resetN(rst2), .RGBIn(rgb2),
        .pixelX(x2), .pixelY(y2), .startOfFrame(sof2),
        .hSync(hs2), .vSync(vs2), .blankN(bn2),
        .red(r2), .green(gn2), .blue(b2)
    );

    obs_t a1, a2;
    assign a1 = {x1, y1, sof1, hs1, vs1, bn1, r1, gn1, b1};
    assign a2 = {x2, y2, sof2, hs2, vs2, bn2, r2, gn2, b2};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: n = clocks since the last reset edge; raster position is plain modular
    // arithmetic, and outputs show the position from lat+1 clocks ago.
    function automatic obs_t model(input geo_t g, input int n, input logic [7:0] prev_rgb);
        int   ht = g.ha + g.hfp + g.hsw + g.hbp;
        int   vt = g.va + g.vfp + g.vsw + g.vbp;
        int   m  = n - 1 - g.lat;
        int   xm, ym, ri, gi, bi;
        obs_t e;
        e.x   = 11'(n % ht);
        e.y   = 11'((n / ht) % vt);
        e.sof = ((n % ht) == 0) && (((n / ht) % vt) == 0);
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.bn  = 1'b0;
        e.r   = '0;
        e.g   = '0;
        e.b   = '0;
        if (m >= 0) begin
            xm   = m % ht;
            ym   = (m / ht) % vt;
            e.hs = !(xm >= g.ha + g.hfp && xm < g.ha + g.hfp + g.hsw);
            e.vs = !(ym >= g.va + g.vfp && ym < g.va + g.vfp + g.vsw);
            e.bn = (xm < g.ha) && (ym < g.va);
            if (e.bn) begin
                ri  = int'(prev_rgb[7:5]);
                gi  = int'(prev_rgb[4:2]);
                bi  = int'(prev_rgb[1:0]);
                e.r = 4'(ri * 2 + ri / 4);
                e.g = 4'(gi * 2 + gi / 4);
                e.b = 4'(bi * 5);
            end
        end
        return e;
    endfunction

    obs_t q1[$];
    obs_t q2[$];
    obs_t e1, e2;

    // Stimulus: compute expectations for the cycle just entered, then drive new inputs.
    initial begin
        int  n1, n2;
        logic s1, s2;
        n1   = 0;
        n2   = 0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        rgb1 = 8'h00;
        rgb2 = 8'h00;
        for (int c = 0; c < RUN; c++) begin
            @(posedge clk);
            s1 = rst1;
            s2 = rst2;
            #1;
            n1 = s1 ? n1 + 1 : 0;
            n2 = s2 ? n2 + 1 : 0;
            q1.push_back(model(geo1, n1, rgb1));
            q2.push_back(model(geo2, n2, rgb2));

            if (c <= 2) begin
                check("rst_hsync", hs1, 1);
                check("rst_vsync", vs1, 1);
                check("rst_blankn", bn1, 0);
                check("rst_rgb", {r1, gn1, b1}, 0);
            end
            if (c == 2) check("release_xy_sof", {x1, y1, sof1}, {11'd0, 11'd0, 1'b1});
            if (c == 3) check("first_step_xy_sof", {x1, y1, sof1}, {11'd1, 11'd0, 1'b0});
            if (c > 2 && !s1) begin
                check("midrst_xy", {x1, y1}, 0);
                check("midrst_sync_blank", {hs1, vs1, bn1}, 3'b110);
                check("midrst_rgb", {r1, gn1, b1}, 0);
            end

            rst1 = (c >= 2) && (n1 != MID_N);
            rst2 = (c >= 2);
            rgb1 = (n1 >= 800 && n1 < 1600) ? 8'hE3 : 8'($urandom);
            rgb2 = (n2 >= 3) ? (8'((n2 - 3) % HT2) ^ 8'hE3) : 8'($urandom);
        end
        repeat (2) @(negedge clk);
        check("sb1_drained", 64'(q1.size()), 0);
        check("sb2_drained", 64'(q2.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Scoreboard monitors: the DUT presents a new output set every clock.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("sb_dut1", a1, e1);
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            check("sb_dut2", a2, e2);
        end
    end

    int   ncyc = 0;
    logic hs1_prev = 1'b1;
    logic vs2_prev = 1'b1;
    logic bn2_prev = 1'b0;
    logic wrap_pending = 1'b0;
    int   hfall = -1, hlow = -1, vfall = -1, vlow = -1;

    // Boundary checks on line/frame timing and colour alignment.
    always @(negedge clk) begin
        ncyc++;
        if (!rst1) begin
            hfall = -1;
            hlow  = -1;
        end else begin
            if (hs1_prev && !hs1) begin
                check("hs_fall_x", x1, 658);
                if (hfall >= 0) check("hs_period", 64'(ncyc - hfall), 800);
                hfall = ncyc;
                hlow  = ncyc;
            end
            if (!hs1_prev && hs1 && hlow >= 0) begin
                check("hs_width", 64'(ncyc - hlow), 96);
                hlow = -1;
            end
            if (y1 == 11'd1 && x1 == 11'd102)
                check("e3_active", {bn1, r1, gn1, b1}, {1'b1, 12'hF0F});
            if (y1 == 11'd1 && x1 == 11'd702)
                check("e3_blanked", {bn1, r1, gn1, b1}, 0);
        end
        hs1_prev = hs1;

        if (rst2) begin
            if (vs2_prev && !vs2) begin
                if (vfall >= 0) check("vs_period", 64'(ncyc - vfall), HT2 * VT2);
                vfall = ncyc;
                vlow  = ncyc;
            end
            if (!vs2_prev && vs2 && vlow >= 0) begin
                check("vs_width", 64'(ncyc - vlow), 2 * HT2);
                vlow = -1;
            end
            if (wrap_pending) check("frame_wrap", {x2, y2, sof2}, {11'd0, 11'd0, 1'b1});
            if (!bn2_prev && bn2) begin
                check("first_vis_rgb", {r2, gn2, b2}, 12'hF0F);
                check("first_vis_x", x2, 4);
            end
        end
        wrap_pending = (x2 == 11'(HT2 - 1)) && (y2 == 11'(VT2 - 1));
        vs2_prev = vs2;
        bn2_prev = bn2;
    end

endmodule
